// File: rtl/reset_seq.sv
// Ordered reset-release sequencer: holds all downstream domains in reset, then
// releases them one at a time, waiting for each acknowledge plus a settle gap.
module reset_seq #(
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT   = 1024
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [NUM_STAGES-1:0] stage_ready_in,
    input  logic                  restart_in,
    output logic [NUM_STAGES-1:0] stage_reset_out,
    output logic                  all_ready_out,
    output logic                  fault_out,
    output logic [1:0]            fault_stage_out
);

    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_WAIT_ACK = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
    localparam logic [1:0]  LAST_IDX    = 2'(NUM_STAGES - 1);

    logic [2:0]            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic                  all_ready_q, all_ready_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fault_stage_q, fault_stage_d;

    logic [3:0]            ready_pad;
    logic [NUM_STAGES-1:0] acked;
    logic [NUM_STAGES-1:0] dropped;
    logic                  drop_any;
    logic [1:0]            drop_idx;

    always_comb begin
        ready_pad = '0;
        ready_pad[NUM_STAGES-1:0] = stage_ready_in;
    end

    // Stages already acknowledged in the current state; losing any of them is a fault.
    always_comb begin
        acked = '0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            if (state_q == S_RUN)
                acked[s] = 1'b1;
            else if (state_q == S_WAIT_ACK && s < 32'(idx_q))
                acked[s] = 1'b1;
            else if (state_q == S_SETTLE && s <= 32'(idx_q))
                acked[s] = 1'b1;
        end
        dropped  = acked & ~stage_ready_in;
        drop_any = |dropped;
        drop_idx = '0;
        for (int unsigned s = NUM_STAGES; s > 0; s--) begin
            if (dropped[s-1])
                drop_idx = 2'(s - 1);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        stage_reset_d = stage_reset_q;
        all_ready_d   = all_ready_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;

        case (state_q)
            S_HOLD: begin
                stage_reset_d = '1;
                if (cnt_q == HOLD_LAST) begin
                    stage_reset_d[0] = 1'b0;
                    cnt_d            = '0;
                    idx_d            = '0;
                    state_d          = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_ACK: begin
                if (drop_any) begin
                    state_d       = S_FAULT;
                    fault_stage_d = drop_idx;
                end else if (ready_pad[idx_q]) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d       = S_FAULT;
                    fault_stage_d = idx_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (drop_any) begin
                    state_d       = S_FAULT;
                    fault_stage_d = drop_idx;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d     = S_RUN;
                        all_ready_d = 1'b1;
                    end else begin
                        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                            if (s == 32'(idx_q) + 32'd1)
                                stage_reset_d[s] = 1'b0;
                        end
                        idx_d   = idx_q + 2'd1;
                        state_d = S_WAIT_ACK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                if (drop_any) begin
                    state_d       = S_FAULT;
                    fault_stage_d = drop_idx;
                end else if (restart_in) begin
                    state_d = S_HOLD;
                end
            end
            S_FAULT: begin
                if (restart_in)
                    state_d = S_HOLD;
            end
            default: state_d = S_HOLD;
        endcase

        // Entry actions shared by every path into FAULT or HOLD.
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            stage_reset_d = '1;
            all_ready_d   = 1'b0;
            fault_d       = 1'b1;
            cnt_d         = '0;
        end
        if (state_d == S_HOLD && state_q != S_HOLD) begin
            stage_reset_d = '1;
            all_ready_d   = 1'b0;
            fault_d       = 1'b0;
            cnt_d         = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            stage_reset_q <= '1;
            all_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stage_reset_q <= stage_reset_d;
            all_ready_q   <= all_ready_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign stage_reset_out = stage_reset_q;
    assign all_ready_out   = all_ready_q;
    assign fault_out       = fault_q;
    assign fault_stage_out = fault_stage_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: emulated stages acknowledge a programmable number of
// cycles after their reset falls; release times come from an arithmetic model.
module tb_reset_seq;

    localparam int NS = 3;
    localparam int H  = 16;
    localparam int S  = 8;
    localparam int T  = 1024;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          restart_in;
    logic [NS-1:0] stage_ready_in;
    logic [NS-1:0] stage_reset_out;
    logic          all_ready_out;
    logic          fault_out;
    logic [1:0]    fault_stage_out;

    logic [NS-1:0] ready_mask = '1;
    logic [NS-1:0] auto_rdy   = '0;
    int            thr[NS]     = '{3, 3, 3};
    int            low_cnt[NS] = '{0, 0, 0};

    int checks = 0;
    int errors = 0;
    int cyc;
    int obs_fall[NS];
    int obs_run;
    int obs_fault;
    int order_bad;

    always #5 clk_in = ~clk_in;

    assign stage_ready_in = auto_rdy & ready_mask;

    reset_seq #(
        .NUM_STAGES   (NS),
        .HOLD_CYCLES  (H),
        .SETTLE_CYCLES(S),
        .ACK_TIMEOUT  (T)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .stage_ready_in (stage_ready_in),
        .restart_in     (restart_in),
        .stage_reset_out(stage_reset_out),
        .all_ready_out  (all_ready_out),
        .fault_out      (fault_out),
        .fault_stage_out(fault_stage_out)
    );

    // Stage emulation: ready once its reset has been low for thr[s] sampled edges.
    always @(posedge clk_in) begin
        #1;
        for (int s = 0; s < NS; s++) begin
            if (stage_reset_out[s] !== 1'b0) low_cnt[s] = 0;
            else low_cnt[s] = low_cnt[s] + 1;
            auto_rdy[s] = (low_cnt[s] >= thr[s]);
        end
    end

    function automatic int exp_fall(input int s);
        int f;
        f = H;
        for (int k = 0; k < s; k++) f = f + thr[k] + S;
        return f;
    endfunction

    function automatic int exp_run();
        return exp_fall(NS - 1) + thr[NS-1] + S;
    endfunction

    task automatic obs_start();
        cyc = 0;
        for (int s = 0; s < NS; s++) obs_fall[s] = -1;
        obs_run   = -1;
        obs_fault = -1;
        order_bad = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        for (int s = 0; s < NS; s++)
            if (obs_fall[s] < 0 && stage_reset_out[s] === 1'b0) obs_fall[s] = cyc;
        for (int s = 1; s < NS; s++)
            if (stage_reset_out[s] === 1'b0 && stage_reset_out[s-1] !== 1'b0) order_bad = 1;
        if (all_ready_out === 1'b1 && obs_run < 0) obs_run = cyc;
        if (fault_out === 1'b1 && obs_fault < 0) obs_fault = cyc;
    endtask

    task automatic obs_until(input int lim);
        while (cyc < lim && obs_run < 0 && obs_fault < 0) tick();
    endtask

    task automatic pulse_restart();
        restart_in = 1'b1;
        @(posedge clk_in);
        #1;
        restart_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in   = 1'b1;
        restart_in = 1'b1;
        ready_mask = '1;
        repeat (3) @(posedge clk_in);
        #1;
        restart_in = 1'b0;
        checks++; if (stage_reset_out !== 3'b111) begin errors++; $display("FAIL reset_stage_reset got %b expected 111", stage_reset_out); end
        checks++; if (all_ready_out !== 1'b0) begin errors++; $display("FAIL reset_all_ready got %b expected 0", all_ready_out); end
        checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL reset_fault got %b expected 0", fault_out); end
        checks++; if (fault_stage_out !== 2'd0) begin errors++; $display("FAIL reset_fault_stage got %0d expected 0", fault_stage_out); end
        reset_in = 1'b0;
        obs_start();
    endtask

    task automatic test_nominal();
        obs_until(200);
        checks++; if (obs_fall[0] != 16) begin errors++; $display("FAIL nominal_fall0 got %0d expected 16", obs_fall[0]); end
        checks++; if (obs_fall[1] != 27) begin errors++; $display("FAIL nominal_fall1 got %0d expected 27", obs_fall[1]); end
        checks++; if (obs_fall[2] != 38) begin errors++; $display("FAIL nominal_fall2 got %0d expected 38", obs_fall[2]); end
        checks++; if (obs_run != 49) begin errors++; $display("FAIL nominal_run got %0d expected 49", obs_run); end
        checks++; if (order_bad != 0) begin errors++; $display("FAIL nominal_order got %0d expected 0", order_bad); end
        repeat (3) tick();
        checks++; if (stage_reset_out !== 3'b000) begin errors++; $display("FAIL run_stage_reset got %b expected 000", stage_reset_out); end
        checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL run_fault got %b expected 0", fault_out); end
    endtask

    task automatic test_restart_settle();
        pulse_restart();
        obs_start();
        checks++; if (stage_reset_out !== 3'b111) begin errors++; $display("FAIL restart_run_stage_reset got %b expected 111", stage_reset_out); end
        checks++; if (all_ready_out !== 1'b0) begin errors++; $display("FAIL restart_run_all_ready got %b expected 0", all_ready_out); end
        obs_until(21);
        restart_in = 1'b1;
        tick();
        restart_in = 1'b0;
        obs_until(200);
        checks++; if (obs_fall[1] != 27) begin errors++; $display("FAIL settle_restart_fall1 got %0d expected 27", obs_fall[1]); end
        checks++; if (obs_run != 49) begin errors++; $display("FAIL settle_restart_run got %0d expected 49", obs_run); end
    endtask

    task automatic test_timeout();
        pulse_restart();
        obs_start();
        ready_mask = 3'b101;
        obs_until(1300);
        checks++; if (obs_fall[1] != 27) begin errors++; $display("FAIL timeout_fall1 got %0d expected 27", obs_fall[1]); end
        checks++; if (obs_fault != 27 + T) begin errors++; $display("FAIL timeout_time got %0d expected %0d", obs_fault, 27 + T); end
        checks++; if (stage_reset_out !== 3'b111) begin errors++; $display("FAIL timeout_stage_reset got %b expected 111", stage_reset_out); end
        checks++; if (fault_stage_out !== 2'd1) begin errors++; $display("FAIL timeout_fault_stage got %0d expected 1", fault_stage_out); end
        checks++; if (all_ready_out !== 1'b0) begin errors++; $display("FAIL timeout_all_ready got %b expected 0", all_ready_out); end
        ready_mask = '1;
        repeat (5) tick();
        checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL fault_hold got %b expected 1", fault_out); end
        checks++; if (stage_reset_out !== 3'b111) begin errors++; $display("FAIL fault_hold_reset got %b expected 111", stage_reset_out); end
    endtask

    task automatic test_restart_fault();
        pulse_restart();
        obs_start();
        checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL restart_fault_clear got %b expected 0", fault_out); end
        checks++; if (fault_stage_out !== 2'd1) begin errors++; $display("FAIL restart_fault_stage_kept got %0d expected 1", fault_stage_out); end
        obs_until(200);
        checks++; if (obs_fall[0] != 16 || obs_fall[1] != 27 || obs_fall[2] != 38) begin
            errors++; $display("FAIL rerun_falls got %0d/%0d/%0d expected 16/27/38", obs_fall[0], obs_fall[1], obs_fall[2]);
        end
        checks++; if (obs_run != 49) begin errors++; $display("FAIL rerun_run got %0d expected 49", obs_run); end
    endtask

    task automatic test_drop_two();
        ready_mask = 3'b010;
        tick();
        checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL drop_fault got %b expected 1", fault_out); end
        checks++; if (fault_stage_out !== 2'd0) begin errors++; $display("FAIL drop_fault_stage got %0d expected 0", fault_stage_out); end
        checks++; if (all_ready_out !== 1'b0) begin errors++; $display("FAIL drop_all_ready got %b expected 0", all_ready_out); end
        checks++; if (stage_reset_out !== 3'b111) begin errors++; $display("FAIL drop_stage_reset got %b expected 111", stage_reset_out); end
        ready_mask = '1;
    endtask

    task automatic test_reset_mid_wait();
        pulse_restart();
        obs_start();
        thr = '{3, 40, 3};
        obs_until(30);
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        checks++; if (stage_reset_out !== 3'b111) begin errors++; $display("FAIL midreset_stage_reset got %b expected 111", stage_reset_out); end
        checks++; if (fault_stage_out !== 2'd0) begin errors++; $display("FAIL midreset_fault_stage got %0d expected 0", fault_stage_out); end
        obs_start();
        obs_until(300);
        checks++; if (obs_fall[0] != exp_fall(0)) begin errors++; $display("FAIL midreset_fall0 got %0d expected %0d", obs_fall[0], exp_fall(0)); end
        checks++; if (obs_fall[2] != exp_fall(2)) begin errors++; $display("FAIL midreset_fall2 got %0d expected %0d", obs_fall[2], exp_fall(2)); end
        checks++; if (obs_run != exp_run()) begin errors++; $display("FAIL midreset_run got %0d expected %0d", obs_run, exp_run()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int r;
            int e;
            logic [NS-1:0] m;
            int low;
            ready_mask = '1;
            pulse_restart();
            obs_start();
            for (int s = 0; s < NS; s++) thr[s] = int'($urandom_range(1, 30));
            e = exp_run();
            r = int'($urandom_range(1, e));
            obs_until(r - 1);
            restart_in = 1'b1;
            tick();
            restart_in = 1'b0;
            obs_until(e + 50);
            for (int s = 0; s < NS; s++) begin
                checks++; if (obs_fall[s] != exp_fall(s)) begin errors++; $display("FAIL rand%0d_fall%0d got %0d expected %0d", it, s, obs_fall[s], exp_fall(s)); end
            end
            checks++; if (obs_run != e) begin errors++; $display("FAIL rand%0d_run got %0d expected %0d", it, obs_run, e); end
            checks++; if (order_bad != 0) begin errors++; $display("FAIL rand%0d_order got %0d expected 0", it, order_bad); end
            if ($urandom_range(0, 1) == 1) begin
                m = NS'($urandom_range(0, 6));
                low = 0;
                while (m[low]) low++;
                ready_mask = m;
                tick();
                checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL rand%0d_drop_fault got %b expected 1", it, fault_out); end
                checks++; if (fault_stage_out !== 2'(low)) begin errors++; $display("FAIL rand%0d_drop_stage got %0d expected %0d", it, fault_stage_out, low); end
            end
        end
    endtask

    initial begin
        reset_in   = 1'b1;
        restart_in = 1'b0;
        test_reset();
        test_nominal();
        test_restart_settle();
        test_timeout();
        test_restart_fault();
        test_drop_two();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning the number of downstream reset domains released in order (range 1..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles all stage resets stay asserted after entering HOLD (range 1..65535).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, meaning the gap in cycles after a stage acknowledges before the next stage is released (range 1..65535).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1024, meaning the maximum cycles to wait for a stage acknowledge (range 1..65535).
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock, which is the PLL output clock.
REQ-006 SHALL have port reset_in, input, 1 bit: synchronous, active-high reset, driven by the PLL's buffered reset output.
REQ-007 SHALL have port stage_ready_in, input, NUM_STAGES bits: per-stage acknowledge, high = stage is out of reset and operational.
REQ-008 SHALL have port restart_in, input, 1 bit: single-cycle request to re-run the sequence.
REQ-009 SHALL have port stage_reset_out, output, NUM_STAGES bits: per-stage active-high reset.
REQ-010 SHALL have port all_ready_out, output, 1 bit: high only in RUN.
REQ-011 SHALL have port fault_out, output, 1 bit: high only in FAULT.
REQ-012 SHALL have port fault_stage_out, output, 2 bits: index of the stage that caused the last fault.

Function
REQ-013 SHALL implement states HOLD, WAIT_ACK, SETTLE, RUN and FAULT, with a 16-bit cycle counter and a 2-bit current-stage index.
REQ-014 SHALL, in HOLD, keep all stage_reset_out bits at 1 and count up; at count HOLD_CYCLES-1 it SHALL clear stage_reset_out[0], zero the counter and enter WAIT_ACK with index 0.
REQ-015 SHALL, in WAIT_ACK, leave in the same cycle stage_ready_in[index] is sampled 1 and enter SETTLE with the counter zeroed.
REQ-016 SHALL, in WAIT_ACK, enter FAULT when the counter reaches ACK_TIMEOUT-1 with no acknowledge, and set fault_stage_out to the current index.
REQ-017 SHALL, in SETTLE at count SETTLE_CYCLES-1, clear stage_reset_out[index+1], increment the index and enter WAIT_ACK; if the index is NUM_STAGES-1 it SHALL instead enter RUN.
REQ-018 SHALL, in WAIT_ACK, SETTLE and RUN, treat a 0 on stage_ready_in for any already-acknowledged stage as a fault: enter FAULT with the lowest such stage index in fault_stage_out.
REQ-019 SHALL give a dropped-acknowledge fault (REQ-018) priority over a timeout (REQ-016) and over normal progress in the same cycle.
REQ-020 SHALL, on entering FAULT, set stage_reset_out to all 1 in the same edge, and hold it there until restart_in is sampled.
REQ-021 SHALL treat restart_in=1 in RUN or FAULT as a command to enter HOLD: counter zeroed, all stage resets 1, fault_out cleared; fault_stage_out SHALL retain its value.
REQ-022 SHALL ignore restart_in in HOLD, WAIT_ACK and SETTLE.
REQ-023 SHALL drive all outputs from registers.
REQ-024 SHALL never deassert a stage reset while any lower-index stage reset is asserted.

Reset
REQ-025 SHALL, while reset_in=1 at a clk_in edge, enter HOLD with the counter and index at 0, stage_reset_out all 1, all_ready_out=0, fault_out=0 and fault_stage_out=0.
REQ-026 SHALL let reset_in override every other input, including during active sequencing.

Verification
REQ-027 Defaults; reset_in low and each stage_ready_in bit set 2 cycles after its stage reset falls -> stage_reset_out[0] falls 16 cycles after reset release, [1] falls 11 cycles later, [2] falls 11 cycles after that, and all_ready_out rises 11 cycles after [2] falls.
REQ-028 stage_ready_in[1] held at 0 -> fault_out=1 exactly 1024 cycles after stage_reset_out[1] falls, with stage_reset_out=3'b111 and fault_stage_out=1.
REQ-029 In RUN, drop stage_ready_in[2] and stage_ready_in[0] in the same cycle -> FAULT next edge, fault_stage_out=0, all_ready_out=0.
REQ-030 restart_in pulsed in FAULT -> HOLD, fault_out=0, and the full sequence of REQ-027 repeats; restart_in pulsed during SETTLE -> no effect.
REQ-031 reset_in pulsed for 1 cycle mid-WAIT_ACK of stage 1 -> stage_reset_out=3'b111 and the counter restarts from 0 in HOLD.
